// File: rtl/mod_sub_seq_if.sv
// Handshake bundle for the word-serial modular subtractor: operand channel in, result channel out.
interface mod_sub_seq_if #(
    parameter int N = 256
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] p;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] diff;
    logic         wrapped;

    modport master (
        output in_valid, a, b, p, out_ready,
        input  in_ready, out_valid, diff, wrapped
    );

    modport slave (
        input  in_valid, a, b, p, out_ready,
        output in_ready, out_valid, diff, wrapped
    );
endinterface

// File: rtl/mod_sub_seq.sv
// Word-serial (a - b) mod p: one W-bit subtract pass with a borrow chain, plus an add-back
// pass of p when the raw difference underflows.
module mod_sub_seq #(
    parameter int N = 256,
    parameter int W = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    mod_sub_seq_if.slave  bus
);
    localparam int K  = N / W;
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(K - 1);

    typedef enum logic [1:0] {IDLE, SUB, FIX, DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          cb_q, cb_d;
    logic          wrapped_q, wrapped_d;
    logic [N-1:0]  opA_q, opA_d;
    logic [N-1:0]  opB_q, opB_d;
    logic [N-1:0]  modP_q, modP_d;
    logic [N-1:0]  result_q, result_d;

    logic [W:0]    subWide;
    logic [W:0]    addWide;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cb_q      <= 1'b0;
            wrapped_q <= 1'b0;
            opA_q     <= '0;
            opB_q     <= '0;
            modP_q    <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cb_q      <= cb_d;
            wrapped_q <= wrapped_d;
            opA_q     <= opA_d;
            opB_q     <= opB_d;
            modP_q    <= modP_d;
            result_q  <= result_d;
        end
    end

    // The extra top bit of each W+1-bit word result is the borrow (SUB) or carry (FIX) out.
    always_comb begin
        subWide = {1'b0, opA_q[idx_q*W +: W]} - {1'b0, opB_q[idx_q*W +: W]}
                  - {{W{1'b0}}, cb_q};
        addWide = {1'b0, result_q[idx_q*W +: W]} + {1'b0, modP_q[idx_q*W +: W]}
                  + {{W{1'b0}}, cb_q};
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cb_d      = cb_q;
        wrapped_d = wrapped_q;
        opA_d     = opA_q;
        opB_d     = opB_q;
        modP_d    = modP_q;
        result_d  = result_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    opA_d     = bus.a;
                    opB_d     = bus.b;
                    modP_d    = bus.p;
                    idx_d     = '0;
                    cb_d      = 1'b0;
                    wrapped_d = 1'b0;
                    state_d   = SUB;
                end
            end
            SUB: begin
                result_d[idx_q*W +: W] = subWide[W-1:0];
                cb_d                   = subWide[W];
                if (idx_q == LastIdx) begin
                    idx_d = '0;
                    if (subWide[W]) begin
                        wrapped_d = 1'b1;
                        cb_d      = 1'b0;
                        state_d   = FIX;
                    end else begin
                        state_d   = DONE;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            FIX: begin
                result_d[idx_q*W +: W] = addWide[W-1:0];
                cb_d                   = addWide[W];
                if (idx_q == LastIdx) begin
                    // Final carry is the expected 2^N overflow of r + p; drop it.
                    idx_d   = '0;
                    cb_d    = 1'b0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.diff      = result_q;
    assign bus.wrapped   = wrapped_q;
endmodule

// File: tb/tb_mod_sub_seq.sv
// Self-checking bench for mod_sub_seq: scoreboard of expected (a - b) mod p results and latencies,
// plus backpressure, back-to-back and asynchronous reset scenarios.
module tb_mod_sub_seq;
    localparam int N = 256;
    localparam int W = 64;
    localparam int K = N / W;

    typedef struct {
        logic [N-1:0] diff;
        logic         wrapped;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    exp_t sbQ[$];
    int   nChecks = 0;
    int   nFails = 0;
    logic [N-1:0] p25519;

    always #5 clk = ~clk;

    mod_sub_seq_if #(.N(N)) busIf();

    mod_sub_seq #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busIf)
    );

    // Reference: exact integer (a - b) mod p for in-range operands; wrap costs a second K-cycle pass.
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] p);
        exp_t e;
        if (a >= b) begin
            e.diff    = a - b;
            e.wrapped = 1'b0;
            e.lat     = K;
        end else begin
            e.diff    = a - b + p;
            e.wrapped = 1'b1;
            e.lat     = 2 * K;
        end
        return e;
    endfunction

    function automatic logic [N-1:0] randBelow(input logic [N-1:0] p);
        logic [N-1:0] x;
        for (int i = 0; i < N / 32; i++) x[i*32 +: 32] = $urandom();
        x[N-1] = 1'b0;
        if (x >= p) x = x - p;
        return x;
    endfunction

    // Returns the number of negedges waited before acceptance (0 if never accepted).
    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] p,
                                 output int tries);
        tries = 0;
        for (int i = 1; i <= 20 && tries == 0; i++) begin
            @(negedge clk);
            if (busIf.in_ready === 1'b1) begin
                busIf.a        = a;
                busIf.b        = b;
                busIf.p        = p;
                busIf.in_valid = 1'b1;
                @(posedge clk);
                #1;
                busIf.in_valid = 1'b0;
                busIf.a        = ~a;
                busIf.b        = ~b;
                busIf.p        = ~p;
                sbQ.push_back(model(a, b, p));
                tries = i;
            end
        end
    endtask

    task automatic waitResult(output int lat, output bit seen);
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (busIf.out_valid === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic doHandshake();
        busIf.out_ready = 1'b1;
        @(posedge clk);
        #1;
        busIf.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        nChecks++;
        if (busIf.in_ready !== 1'b1 || busIf.out_valid !== 1'b0 ||
            busIf.diff !== '0 || busIf.wrapped !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL reset_values: got rdy=%b vld=%b wr=%b diff=%h, want rdy=1 vld=0 wr=0 diff=0",
                     busIf.in_ready, busIf.out_valid, busIf.wrapped, busIf.diff);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_arithmetic();
        logic [N-1:0] va[12], vb[12], vp[12];
        logic [N-1:0] one = 1;
        int   tries, lat;
        bit   seen;
        exp_t e;
        va[0] = 10;            vb[0] = 3;               vp[0] = p25519;
        va[1] = 3;             vb[1] = 10;              vp[1] = p25519;
        va[2] = one << 64;     vb[2] = 1;               vp[2] = p25519;
        va[3] = one << 192;    vb[3] = 1;               vp[3] = p25519;
        va[4] = p25519 - 1;    vb[4] = p25519 - 1;      vp[4] = p25519;
        va[5] = 0;             vb[5] = p25519 - 1;      vp[5] = p25519;
        va[6] = one << 64;     vb[6] = (one << 64) + 1; vp[6] = (one << 64) + 5;
        va[7] = 0;             vb[7] = 0;               vp[7] = p25519;
        for (int i = 8; i < 12; i++) begin
            vp[i] = p25519;
            va[i] = randBelow(p25519);
            vb[i] = randBelow(p25519);
        end
        for (int i = 0; i < 12; i++) begin
            applyStimulus(va[i], vb[i], vp[i], tries);
            nChecks++;
            if (tries == 0) begin
                nFails++;
                $display("[TB] FAIL arith_accept[%0d]: in_ready never high, want accept", i);
                continue;
            end
            waitResult(lat, seen);
            e = sbQ.pop_front();
            nChecks++;
            if (!seen || lat != e.lat) begin
                nFails++;
                $display("[TB] FAIL arith_latency[%0d]: got %0d (seen=%0b) want %0d", i, lat, seen, e.lat);
            end
            nChecks++;
            if (busIf.diff !== e.diff) begin
                nFails++;
                $display("[TB] FAIL arith_diff[%0d]: got %h want %h", i, busIf.diff, e.diff);
            end
            nChecks++;
            if (busIf.wrapped !== e.wrapped) begin
                nFails++;
                $display("[TB] FAIL arith_wrapped[%0d]: got %b want %b", i, busIf.wrapped, e.wrapped);
            end
            doHandshake();
        end
    endtask

    task automatic test_backpressure();
        int   tries, lat, bad;
        bit   seen;
        exp_t e;
        logic [N-1:0] d0;
        logic w0;
        applyStimulus(3, 10, p25519, tries);
        waitResult(lat, seen);
        e = sbQ.pop_front();
        nChecks++;
        if (!seen || busIf.diff !== e.diff || busIf.wrapped !== e.wrapped) begin
            nFails++;
            $display("[TB] FAIL bp_result: got seen=%0b diff=%h wr=%b want diff=%h wr=%b",
                     seen, busIf.diff, busIf.wrapped, e.diff, e.wrapped);
        end
        d0  = busIf.diff;
        w0  = busIf.wrapped;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (busIf.out_valid !== 1'b1 || busIf.diff !== d0 ||
                busIf.wrapped !== w0 || busIf.in_ready !== 1'b0) bad++;
        end
        nChecks++;
        if (bad != 0) begin
            nFails++;
            $display("[TB] FAIL bp_hold: got %0d unstable cycles want 0", bad);
        end
        doHandshake();
        nChecks++;
        if (busIf.in_ready !== 1'b1 || busIf.out_valid !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL bp_release: got rdy=%b vld=%b want rdy=1 vld=0",
                     busIf.in_ready, busIf.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int   tries, lat;
        bit   seen;
        exp_t e;
        applyStimulus(p25519 - 1, 5, p25519, tries);
        nChecks++;
        if (tries != 1) begin
            nFails++;
            $display("[TB] FAIL b2b_accept: got accept on try %0d want 1", tries);
        end
        busIf.out_ready = 1'b1;
        waitResult(lat, seen);
        e = sbQ.pop_front();
        nChecks++;
        if (!seen || lat != e.lat || busIf.diff !== e.diff || busIf.wrapped !== e.wrapped) begin
            nFails++;
            $display("[TB] FAIL b2b_result: got lat=%0d diff=%h wr=%b want lat=%0d diff=%h wr=%b",
                     lat, busIf.diff, busIf.wrapped, e.lat, e.diff, e.wrapped);
        end
        @(posedge clk);
        #1;
        busIf.out_ready = 1'b0;
        nChecks++;
        if (busIf.out_valid !== 1'b0 || busIf.in_ready !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL early_ready_handshake: got vld=%b rdy=%b want vld=0 rdy=1",
                     busIf.out_valid, busIf.in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int   tries, lat, vcount;
        bit   seen;
        exp_t e;
        int   depth[2] = '{2, K + 2};
        for (int s = 0; s < 2; s++) begin
            applyStimulus(3, 10, p25519, tries);
            repeat (depth[s]) @(posedge clk);
            #3 rst_n = 1'b0;
            #1;
            nChecks++;
            if (busIf.in_ready !== 1'b1 || busIf.out_valid !== 1'b0 ||
                busIf.diff !== '0 || busIf.wrapped !== 1'b0) begin
                nFails++;
                $display("[TB] FAIL mid_reset[%0d]: got rdy=%b vld=%b wr=%b diff=%h want 1 0 0 0",
                         s, busIf.in_ready, busIf.out_valid, busIf.wrapped, busIf.diff);
            end
            sbQ.delete();
            @(negedge clk);
            rst_n = 1'b1;
            vcount = 0;
            for (int i = 0; i < 12; i++) begin
                @(posedge clk);
                #1;
                if (busIf.out_valid !== 1'b0) vcount++;
            end
            nChecks++;
            if (vcount != 0) begin
                nFails++;
                $display("[TB] FAIL post_reset_idle[%0d]: got %0d valid cycles want 0", s, vcount);
            end
        end
        applyStimulus(10, 3, p25519, tries);
        waitResult(lat, seen);
        e = sbQ.pop_front();
        nChecks++;
        if (!seen || lat != e.lat || busIf.diff !== e.diff || busIf.wrapped !== e.wrapped) begin
            nFails++;
            $display("[TB] FAIL post_reset_op: got lat=%0d diff=%h wr=%b want lat=%0d diff=%h wr=%b",
                     lat, busIf.diff, busIf.wrapped, e.lat, e.diff, e.wrapped);
        end
        doHandshake();
    endtask

    initial begin
        p25519          = (256'd1 << 255) - 256'd19;
        busIf.in_valid  = 1'b0;
        busIf.out_ready = 1'b0;
        busIf.a         = '0;
        busIf.b         = '0;
        busIf.p         = '0;
        test_reset();
        test_arithmetic();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/mod_sub_seq.md
# mod_sub_seq

Sequential modular subtractor. Computes diff = (a − b) mod p over N-bit operands, one W-bit word per cycle, with a borrow chain between words. If the raw difference underflows, a second word-serial pass adds p back. It is the subtract-direction companion to the team's N-bit ripple and carry-lookahead adders in the field-arithmetic datapath. It trades latency for a W-bit carry path, so a 256-bit subtract does not need a 256-bit ripple chain.

## Interface
- N, 256, operand width in bits; must be a multiple of W
- W, 64, word width processed per cycle; K = N/W words
- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands a, b, p are presented
- in_ready  out  1  block can accept operands (high only in IDLE)
- a  in  N  minuend; the caller guarantees a < p
- b  in  N  subtrahend; the caller guarantees b < p
- p  in  N  modulus, nonzero
- out_valid  out  1  diff and wrapped are valid
- out_ready  in  1  consumer accepts the result
- diff  out  N  (a − b) mod p, in the range [0, p)
- wrapped  out  1  set when a < b, meaning the correction pass ran

## Operation
- States: IDLE, SUB, FIX, DONE. A 2-bit state register, a word index idx over 0..K−1, and a 1-bit carry/borrow register cb.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, latch a, b and p into internal registers; later changes on the inputs are ignored.
  - Set idx = 0, cb = 0, wrapped = 0, and go to SUB.
- SUB: each cycle, word idx of the result register = a_w − b_w − cb, computed modulo 2^W. cb takes the borrow out of that word. idx increments.
  - After word K−1, if the final borrow is 1, set wrapped = 1, clear cb, reset idx to 0 and go to FIX.
  - After word K−1, if the final borrow is 0, go to DONE.
- FIX: each cycle, word idx of the result register = r_w + p_w + cb, computed modulo 2^W. cb takes the carry out. idx increments.
  - After word K−1, go to DONE. The final carry out is discarded; it is always 1 when the input preconditions hold.
- DONE:
  - out_valid = 1. diff and wrapped are held stable.
  - On out_valid && out_ready, go to IDLE.
- Arithmetic is exact modulo 2^N per pass. No carry or borrow is lost between words.
- Inputs that break a < p or b < p give an unspecified diff, but the state machine must still reach DONE with the normal latency. It must not hang.

## Timing
- Reset values:
  - state = IDLE
  - in_ready = 1, out_valid = 0
  - diff = 0, wrapped = 0
  - idx = 0, cb = 0
- Let the accept edge be edge 0.
- No wrap: SUB occupies the K cycles after edge 0, and out_valid rises after edge K. Latency is K+1 cycles; for the defaults, out_valid is high in cycle 5.
- Wrap: FIX occupies K further cycles, and out_valid rises after edge 2K. For the defaults, out_valid is high in cycle 9.
- in_ready is low from the accept edge until the DONE handshake edge.
- in_ready goes high the cycle after that handshake. There is no overlap of successive operations.
- Maximum throughput is one result per K+2 cycles without wrap, and one per 2K+2 cycles with wrap.
- Backpressure: out_valid stays high and diff and wrapped stay constant indefinitely while out_ready = 0.
- If out_ready is already high when DONE is entered, the handshake completes on the first DONE edge.
- in_valid is ignored outside IDLE.
- Reset asserted mid-operation, in any state, immediately forces the reset values. No partial result is ever presented after reset.
- diff is a registered output. Intermediate words may be visible during SUB and FIX but are qualified only by out_valid.

## Test plan
1. Defaults N=256, W=64, p = 2^255−19; a = 10, b = 3 → diff = 7, wrapped = 0, out_valid high in cycle 5 after accept.
2. Same p; a = 3, b = 10 → diff = 2^255−26, wrapped = 1, out_valid high in cycle 9.
3. Cross-word borrow, with a = 2^64, b = 1, any p > a:
   - diff = 2^64−1 (word 0 all ones, word 1 zero), wrapped = 0.
   - a = 2^192, b = 1 → diff = 2^192−1.
4. a = b = p−1 → diff = 0, wrapped = 0. Also a = 0, b = p−1 → diff = 1, wrapped = 1.
5. Backpressure: hold out_ready = 0 for 20 cycles in DONE. diff, wrapped and out_valid must not change, and in_ready must stay 0. Then pulse out_ready for 1 cycle → in_ready = 1 the next cycle, and a back-to-back operation is accepted.
6. Reset: assert rst_n = 0 during SUB (idx = 2) and again during FIX. Outputs must reach their reset values asynchronously. After release, a fresh a = 10, b = 3 gives diff = 7 with nominal latency.
